// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and FSM encoding for the MIPS pipeline control blocks
package mips_pkg;

    localparam int REG_W = 5;

    localparam int DEF_STALL_CYCLES = 1;
    localparam int DEF_FLUSH_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use stall and taken-branch flush sequencing for the 5-stage pipeline
module hazard_controller
    import mips_pkg::*;
#(
    parameter int STALL_CYCLES = DEF_STALL_CYCLES,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_br_taken,
    output logic             d_h,
    output logic             c_h,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] redirect_count
);

    // cnt holds the number of window cycles still to run after the current one
    localparam int MAXC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC - 1) : 1;
    localparam logic [CW-1:0] STALL_RELOAD = (STALL_CYCLES > 1) ? CW'(STALL_CYCLES - 2) : '0;
    localparam logic [CW-1:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? CW'(FLUSH_CYCLES - 2) : '0;

    hz_state_t       state;
    logic [CW-1:0]   cnt;
    logic            hz;
    logic            br;

    assign hz = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    assign br = ex_valid & ex_br_taken;

    always_comb begin
        d_h            = 1'b0;
        c_h            = 1'b0;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        if (!reset) begin
            if (br) begin
                c_h         = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                case (state)
                    ST_FLUSH: begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                    ST_STALL: begin
                        d_h            = 1'b1;
                        if_id_write_en = 1'b0;
                        id_ex_flush    = 1'b1;
                    end
                    default: begin
                        if (hz) begin
                            d_h            = 1'b1;
                            if_id_write_en = 1'b0;
                            id_ex_flush    = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else if (br) begin
            if (FLUSH_CYCLES > 1) begin
                state <= ST_FLUSH;
                cnt   <= FLUSH_RELOAD;
            end else begin
                state <= ST_RUN;
            end
        end else begin
            case (state)
                ST_STALL, ST_FLUSH: begin
                    if (cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    if (hz && (STALL_CYCLES > 1)) begin
                        state <= ST_STALL;
                        cnt   <= STALL_RELOAD;
                    end
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (d_h),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (c_h),
        .count (redirect_count)
    );

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the program counter's data-hazard hold (d_h) and control-hazard redirect (c_h), plus the IF/ID write enable and the IF/ID and ID/EX flush strobes.
- Detects load-use hazards between ID and EX, and resolves taken branches in EX.
- Sequences multi-cycle stall and flush windows with a small FSM and keeps saturating performance counters.

Parameters:
- STALL_CYCLES, 1, bubble cycles per load-use hazard (>=1).
- FLUSH_CYCLES, 2, cycles of IF/ID and ID/EX flush per redirect (>=1).
- CNT_W, 32, width of the performance counters.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  5  ID source register rs.
- id_rt  input  5  ID source register rt.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_mem_read  input  1  EX instruction is a load.
- ex_rt  input  5  EX load destination register.
- ex_br_taken  input  1  EX branch/jump resolved taken.
- d_h  output  1  PC hold/re-fetch (data hazard).
- c_h  output  1  PC redirect (control hazard).
- if_id_write_en  output  1  IF/ID register load enable.
- if_id_flush  output  1  clear IF/ID to bubble.
- id_ex_flush  output  1  clear ID/EX to bubble.
- stall_count  output  CNT_W  cycles with d_h=1.
- redirect_count  output  CNT_W  cycles with c_h=1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: state=RUN, internal cnt=0, stall_count=0, redirect_count=0.
- Control outputs while reset=1: d_h=0, c_h=0, if_id_flush=0, id_ex_flush=0, if_id_write_en=1.
- Hazard term:
  - hz = id_valid & ex_valid & ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
  - br = ex_valid & ex_br_taken.
- Control outputs are combinational from state and the current inputs; they are consumed at the same clock edge (0-cycle latency).
- d_h and c_h are never both 1. br has priority over hz in every state.
- RUN:
  - If br: c_h=1, if_id_flush=1, id_ex_flush=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-2; otherwise stay in RUN.
  - Else if hz: d_h=1, if_id_write_en=0, id_ex_flush=1. If STALL_CYCLES>1, go to STALL with cnt=STALL_CYCLES-2; otherwise stay in RUN.
  - Else all strobes 0 and if_id_write_en=1.
- STALL:
  - If br: act exactly as the RUN br case, which abandons the stall.
  - Else: d_h=1, if_id_write_en=0, id_ex_flush=1. hz is not re-evaluated. If cnt==0, go to RUN; otherwise decrement cnt.
- FLUSH:
  - if_id_flush=1, id_ex_flush=1, c_h=0, d_h=0, if_id_write_en=1. hz is ignored.
  - If br, act as the RUN br case, which restarts the window (FLUSH_CYCLES-1 further cycles). Otherwise, if cnt==0 go to RUN, else decrement cnt.
- Back-to-back: a hazard in the first RUN cycle after STALL or FLUSH is serviced normally, with no dead cycle.
- Counters:
  - stall_count increments on every non-reset cycle with d_h=1.
  - redirect_count increments on every non-reset cycle with c_h=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-STALL or mid-FLUSH aborts to RUN on the next edge. Strobes are forced inactive during the reset cycle.
- Register 0 never causes a stall.

Decomposition:
- Shared package mips_pkg:
  - REG_W=5.
  - FSM state encoding RUN/STALL/FLUSH (2-bit).
  - Default STALL_CYCLES and FLUSH_CYCLES constants.
- One sub-module, sat_counter (width CNT_W, inc input, synchronous reset), instantiated twice for the performance counters.
- Hazard comparison stays inline.

Test Plan:
- Load-use hazard, defaults: ex_mem_read=1, ex_rt=8, id_rs=8, all valids=1 for one cycle -> that cycle d_h=1, if_id_write_en=0, id_ex_flush=1; next cycle (EX bubble) d_h=0; stall_count=1.
- Taken branch: ex_br_taken=1, ex_valid=1 -> cycle0 c_h=1 with both flushes=1; cycle1 both flushes=1 and c_h=0; cycle2 all strobes=0; redirect_count=1.
- Simultaneous hz and br (ex_rt=id_rs=8, load, taken): c_h=1 and d_h=0; stall_count remains 0.
- Zero register and rt qualification:
  - ex_rt=0, id_rs=0 -> no stall.
  - ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
  - Same with id_uses_rt=1 -> stall.
- STALL_CYCLES=3: a single hazard -> d_h=1 for exactly 3 cycles; reset asserted in cycle 2 -> outputs inactive that cycle, state RUN after, counters 0.
- Saturation, CNT_W=4: hold hz continuously for 20 cycles -> stall_count reaches 15 and stays 15.
